// File: rtl/ccc_seq_pkg.sv
// Shared state encoding, widths and default timing constants for the CCC lock
// sequencer and its sub-blocks.
package ccc_seq_pkg;

  localparam int STATE_W           = 2;
  localparam int CTR_W             = 16;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_HOLD_CYCLES   = 64;
  localparam int DEF_CNT_W         = 8;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } seq_state_e;

  // Terminal value of the shared counter for a phase lasting 'cycles' clocks.
  function automatic logic [CTR_W-1:0] last_count(input int cycles);
    return CTR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ccc_lock_sequencer_if.sv
// Internal bundle between the lock-input front end and the sequencing FSM.
interface ccc_lock_sequencer_if #(
  parameter int CNT_W = ccc_seq_pkg::DEF_CNT_W
) ();

  logic                               lock_s;
  logic                               sw_rst_req;
  logic                               cnt_clr;
  logic                               fab_reset_n;
  logic [CNT_W-1:0]                   loss_cnt;
  logic [ccc_seq_pkg::STATE_W-1:0]    seq_state;

  modport master (
    output lock_s,
    output sw_rst_req,
    output cnt_clr,
    input  fab_reset_n,
    input  loss_cnt,
    input  seq_state
  );

  modport slave (
    input  lock_s,
    input  sw_rst_req,
    input  cnt_clr,
    output fab_reset_n,
    output loss_cnt,
    output seq_state
  );

endinterface

// File: rtl/ccc_lock_sequencer_fsm.sv
// Fabric reset sequencing FSM: waits for stable lock, releases the fabric
// reset, and re-holds it on lock loss or software request.
module ccc_lock_sequencer_fsm
  import ccc_seq_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ccc_lock_sequencer_if.slave  seq_if
);

  localparam logic [CTR_W-1:0] STABLE_LAST = last_count(STABLE_CYCLES);
  localparam logic [CTR_W-1:0] HOLD_LAST   = last_count(HOLD_CYCLES);

  seq_state_e       state_q;
  logic [CTR_W-1:0] ctr_q;
  logic             fab_rst_n_q;
  logic [CNT_W-1:0] loss_q;
  logic [CNT_W-1:0] loss_d;
  logic             lock_lost;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A loss only counts while the fabric is running; a dropout during
  // stabilization just restarts the wait.
  assign lock_lost = (state_q == RUN) && !seq_if.lock_s;

  always_comb begin
    loss_d = loss_q;
    if (seq_if.cnt_clr) begin
      loss_d = '0;
    end else if (lock_lost) begin
      loss_d = sat_inc(loss_q);
    end
  end

  // One counter serves both the stabilize window and the hold window; it is
  // zeroed on every state entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WAIT_LOCK;
      ctr_q       <= '0;
      fab_rst_n_q <= 1'b0;
      loss_q      <= '0;
    end else begin
      loss_q <= loss_d;
      case (state_q)
        WAIT_LOCK: begin
          if (seq_if.lock_s) begin
            state_q <= STABILIZE;
            ctr_q   <= '0;
          end
        end
        STABILIZE: begin
          if (!seq_if.lock_s) begin
            state_q <= WAIT_LOCK;
            ctr_q   <= '0;
          end else if (ctr_q == STABLE_LAST) begin
            state_q     <= RUN;
            ctr_q       <= '0;
            fab_rst_n_q <= 1'b1;
          end else begin
            ctr_q <= ctr_q + CTR_W'(1);
          end
        end
        RUN: begin
          if (!seq_if.lock_s || seq_if.sw_rst_req) begin
            state_q     <= HOLD;
            ctr_q       <= '0;
            fab_rst_n_q <= 1'b0;
          end
        end
        default: begin
          if (ctr_q == HOLD_LAST) begin
            state_q <= WAIT_LOCK;
            ctr_q   <= '0;
          end else begin
            ctr_q <= ctr_q + CTR_W'(1);
          end
        end
      endcase
    end
  end

  assign seq_if.fab_reset_n = fab_rst_n_q;
  assign seq_if.loss_cnt    = loss_q;
  assign seq_if.seq_state   = state_q;

endmodule

// File: rtl/ccc_lock_sequencer_sync.sv
// Two-flop synchronizer for a single asynchronous level (PLL lock indicator).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ccc_lock_sequencer.sv
// CCC lock sequencer top: synchronizes both PLL locks and sequences the
// fabric reset release off the single RC-oscillator clock.
module ccc_lock_sequencer
  import ccc_seq_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               FAB_LOCK,
  input  logic               MSS_LOCK,
  input  logic               SW_RST_REQ,
  input  logic               CNT_CLR,
  output logic               FAB_RESET_N,
  output logic               LOCK_OK,
  output logic [CNT_W-1:0]   LOSS_CNT,
  output logic [STATE_W-1:0] SEQ_STATE
);

  logic fab_lock_s;
  logic mss_lock_s;

  ccc_lock_sequencer_if #(.CNT_W(CNT_W)) seq_if ();

  sync_2ff u_sync_fab (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (FAB_LOCK),
    .q_o    (fab_lock_s)
  );

  sync_2ff u_sync_mss (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (MSS_LOCK),
    .q_o    (mss_lock_s)
  );

  assign seq_if.lock_s     = fab_lock_s & mss_lock_s;
  assign seq_if.sw_rst_req = SW_RST_REQ;
  assign seq_if.cnt_clr    = CNT_CLR;

  ccc_lock_sequencer_fsm #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .CNT_W         (CNT_W)
  ) u_fsm (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .seq_if (seq_if)
  );

  assign FAB_RESET_N = seq_if.fab_reset_n;
  assign LOCK_OK     = seq_if.lock_s;
  assign LOSS_CNT    = seq_if.loss_cnt;
  assign SEQ_STATE   = seq_if.seq_state;

endmodule
